// File: rtl/quickq_pkg.sv
// Shared types for the QuickQ sorted-array priority queue sequencer.
// Holds the command opcodes, sequencer states and response error codes.
package quickq_pkg;

    localparam int QQ_DEPTH = 16;
    localparam int QQ_KEY_W = 32;

    typedef enum logic [1:0] {
        OP_INSERT = 2'd0,
        OP_REMOVE = 2'd1,
        OP_CLEAR  = 2'd2,
        OP_ILL    = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_INS_WALK,
        S_REM_WALK,
        S_DONE
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE,
        ERR_FULL,
        ERR_EMPTY,
        ERR_ILL_OP
    } err_e;

endpackage

// File: rtl/quickq_seq_ctrl_if.sv
// Command/response handshake between a QuickQ client and the sequencer.
// The client holds the master modport and the sequencer holds the slave modport.
interface quickq_seq_ctrl_if #(
    parameter int KEY_W = 32
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [KEY_W-1:0] cmd_key;
    logic             rsp_valid;
    logic             rsp_err;
    logic [KEY_W-1:0] rsp_key;

    modport master (
        output cmd_valid, cmd_op, cmd_key,
        input  cmd_ready, rsp_valid, rsp_err, rsp_key
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_key,
        output cmd_ready, rsp_valid, rsp_err, rsp_key
    );
endinterface

// File: rtl/quickq_seq_ctrl.sv
// QuickQ sequencer: insertion-sort INSERT, pop-minimum REMOVE and CLEAR over an
// external key memory, steering an external array-pointer counter one step per cycle.
module quickq_seq_ctrl
    import quickq_pkg::*;
#(
    parameter int  DEPTH = QQ_DEPTH,
    parameter int  KEY_W = QQ_KEY_W,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    quickq_seq_ctrl_if.slave  cmd,
    output logic              cnt_rst,
    output logic              array_cnt_ld,
    output logic              array_cnt_clr,
    output logic              array_cnt_decr,
    output logic              array_cnt_inc,
    output logic [31:0]       last_index,
    input  logic [31:0]       pointer,
    output logic [31:0]       mem_raddr,
    input  logic [KEY_W-1:0]  mem_rdata,
    output logic              mem_we,
    output logic [31:0]       mem_waddr,
    output logic [KEY_W-1:0]  mem_wdata,
    output logic [CW-1:0]     count
);

    state_e           state_q,   state_d;
    op_e              op_q,      op_d;
    err_e             err_q,     err_d;
    logic [CW-1:0]    count_q,   count_d;
    logic [KEY_W-1:0] key_q,     key_d;
    logic [KEY_W-1:0] rsp_key_q, rsp_key_d;

    logic full, empty;

    assign full        = (count_q == CW'(DEPTH));
    assign empty       = (count_q == '0);
    assign count       = count_q;
    assign last_index  = 32'(count_q);
    assign cmd.rsp_key = rsp_key_q;
    assign cmd.rsp_err = (state_q == S_DONE) && (err_q != ERR_NONE);

    // NOTE: every output and next-state value gets a default before the case so
    // that no path leaves a signal unassigned and infers a latch.
    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        err_d          = err_q;
        count_d        = count_q;
        key_d          = key_q;
        rsp_key_d      = rsp_key_q;
        cnt_rst        = 1'b0;
        array_cnt_ld   = 1'b0;
        array_cnt_clr  = 1'b0;
        array_cnt_decr = 1'b0;
        array_cnt_inc  = 1'b0;
        mem_raddr      = '0;
        mem_we         = 1'b0;
        mem_waddr      = '0;
        mem_wdata      = '0;
        cmd.cmd_ready  = 1'b0;
        cmd.rsp_valid  = 1'b0;

        case (state_q)
            S_IDLE: begin
                cmd.cmd_ready = 1'b1;
                if (cmd.cmd_valid) begin
                    op_d      = op_e'(cmd.cmd_op);
                    err_d     = ERR_NONE;
                    rsp_key_d = '0;
                    state_d   = S_DONE;
                    case (op_e'(cmd.cmd_op))
                        OP_INSERT: begin
                            if (full) begin
                                err_d = ERR_FULL;
                            end else begin
                                key_d        = cmd.cmd_key;
                                array_cnt_ld = 1'b1;
                                state_d      = S_INS_WALK;
                            end
                        end
                        OP_REMOVE: begin
                            // mem_raddr is 0 here, so mem_rdata is the current minimum.
                            if (empty) begin
                                err_d = ERR_EMPTY;
                            end else begin
                                rsp_key_d     = mem_rdata;
                                array_cnt_clr = 1'b1;
                                state_d       = S_REM_WALK;
                            end
                        end
                        OP_CLEAR: begin
                            cnt_rst = 1'b1;
                            count_d = '0;
                        end
                        default: err_d = ERR_ILL_OP;
                    endcase
                end
            end

            S_INS_WALK: begin
                mem_raddr = pointer - 32'd1;
                mem_we    = 1'b1;
                mem_waddr = pointer;
                // Stopping on <= places the new key after equal keys, keeping FIFO order.
                if (pointer == '0 || mem_rdata <= key_q) begin
                    mem_wdata = key_q;
                    state_d   = S_DONE;
                end else begin
                    mem_wdata      = mem_rdata;
                    array_cnt_decr = 1'b1;
                end
            end

            S_REM_WALK: begin
                mem_raddr = pointer + 32'd1;
                if (pointer + 32'd1 >= 32'(count_q)) begin
                    state_d = S_DONE;
                end else begin
                    mem_we        = 1'b1;
                    mem_waddr     = pointer;
                    mem_wdata     = mem_rdata;
                    array_cnt_inc = 1'b1;
                end
            end

            S_DONE: begin
                cmd.rsp_valid = 1'b1;
                err_d         = ERR_NONE;
                state_d       = S_IDLE;
                if (err_q == ERR_NONE) begin
                    case (op_q)
                        OP_INSERT: count_d = count_q + CW'(1);
                        OP_REMOVE: count_d = count_q - CW'(1);
                        default:   count_d = count_q;
                    endcase
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values computed above, independent of evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            op_q      <= OP_INSERT;
            err_q     <= ERR_NONE;
            count_q   <= '0;
            key_q     <= '0;
            rsp_key_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            err_q     <= err_d;
            count_q   <= count_d;
            key_q     <= key_d;
            rsp_key_q <= rsp_key_d;
        end
    end

endmodule

// File: tb/tb_quickq_seq_ctrl.sv
// Directed bench for quickq_seq_ctrl with a behavioural array pointer and key memory.
// Each scenario task drives commands and compares against hand-computed values.
module tb_quickq_seq_ctrl;

    localparam int DEPTH = 16;
    localparam int KEY_W = 32;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int AW    = $clog2(DEPTH);

    logic             clk;
    logic             rst_n;
    logic             cnt_rst, array_cnt_ld, array_cnt_clr, array_cnt_decr, array_cnt_inc;
    logic [31:0]      last_index;
    logic [31:0]      pointer;
    logic [31:0]      mem_raddr;
    logic [KEY_W-1:0] mem_rdata;
    logic             mem_we;
    logic [31:0]      mem_waddr;
    logic [KEY_W-1:0] mem_wdata;
    logic [CW-1:0]    count;

    int total = 0;
    int bad   = 0;

    quickq_seq_ctrl_if #(.KEY_W(KEY_W)) cmd_if ();

    quickq_seq_ctrl #(.DEPTH(DEPTH), .KEY_W(KEY_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cmd            (cmd_if),
        .cnt_rst        (cnt_rst),
        .array_cnt_ld   (array_cnt_ld),
        .array_cnt_clr  (array_cnt_clr),
        .array_cnt_decr (array_cnt_decr),
        .array_cnt_inc  (array_cnt_inc),
        .last_index     (last_index),
        .pointer        (pointer),
        .mem_raddr      (mem_raddr),
        .mem_rdata      (mem_rdata),
        .mem_we         (mem_we),
        .mem_waddr      (mem_waddr),
        .mem_wdata      (mem_wdata),
        .count          (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sibling array-pointer counter and key memory, as they sit in the QuickQ top.
    logic [KEY_W-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if      (cnt_rst)        pointer <= '0;
        else if (array_cnt_ld)   pointer <= last_index;
        else if (array_cnt_clr)  pointer <= '0;
        else if (array_cnt_decr) pointer <= pointer - 32'd1;
        else if (array_cnt_inc)  pointer <= pointer + 32'd1;
        if (mem_we) mem[mem_waddr[AW-1:0]] <= mem_wdata;
    end
    assign mem_rdata = mem[mem_raddr[AW-1:0]];

    int we_cnt = 0, rsp_cnt = 0, cnt_rst_cnt = 0, overlap_cnt = 0;
    always @(posedge clk) begin
        if (mem_we) we_cnt <= we_cnt + 1;
        if (cmd_if.rsp_valid) rsp_cnt <= rsp_cnt + 1;
        if (cnt_rst) cnt_rst_cnt <= cnt_rst_cnt + 1;
        if ($countones({cnt_rst, array_cnt_ld, array_cnt_clr, array_cnt_decr, array_cnt_inc}) > 1)
            overlap_cnt <= overlap_cnt + 1;
    end

    // Issues one command from IDLE; lat counts cycles from accept to rsp_valid (0 = timeout).
    task automatic do_op(input logic [1:0] op, input logic [KEY_W-1:0] key,
                         output int lat, output logic err, output logic [KEY_W-1:0] rkey);
        @(negedge clk);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = op;
        cmd_if.cmd_key   = key;
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
        lat  = 0;
        err  = 1'bx;
        rkey = 'x;
        for (int c = 1; c <= 64; c++) begin
            if (cmd_if.rsp_valid) begin
                lat  = c;
                err  = cmd_if.rsp_err;
                rkey = cmd_if.rsp_key;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n            = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = 2'd0;
        cmd_if.cmd_key   = '0;
        repeat (2) @(negedge clk);
        total++;
        if (cmd_if.cmd_ready !== 1'b1 || count !== '0 || last_index !== 32'd0) begin
            bad++;
            $display("FAIL reset_state: ready=%b count=%0d last_index=%0d want 1/0/0",
                     cmd_if.cmd_ready, count, last_index);
        end
        total++;
        if ({cnt_rst, array_cnt_ld, array_cnt_clr, array_cnt_decr, array_cnt_inc, mem_we,
             cmd_if.rsp_valid, cmd_if.rsp_err} !== 8'h00 || cmd_if.rsp_key !== '0) begin
            bad++;
            $display("FAIL reset_outputs: strobes/we/rsp not all zero, rsp_key=%0d", cmd_if.rsp_key);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_insert_sort();
        logic [KEY_W-1:0] keys [3] = '{32'd5, 32'd3, 32'd9};
        int               lats [3] = '{2, 3, 2};
        int lat; logic err; logic [KEY_W-1:0] rk;
        for (int i = 0; i < 3; i++) begin
            do_op(2'd0, keys[i], lat, err, rk);
            total++;
            if (lat !== lats[i] || err !== 1'b0 || rk !== '0) begin
                bad++;
                $display("FAIL insert_%0d: lat=%0d err=%b key=%0d want lat=%0d err=0 key=0",
                         keys[i], lat, err, rk, lats[i]);
            end
        end
        total++;
        if (mem[0] !== 32'd3 || mem[1] !== 32'd5 || mem[2] !== 32'd9) begin
            bad++;
            $display("FAIL insert_order: mem=%0d,%0d,%0d want 3,5,9", mem[0], mem[1], mem[2]);
        end
        total++;
        if (count !== CW'(3) || last_index !== 32'd3) begin
            bad++;
            $display("FAIL insert_count: count=%0d last_index=%0d want 3", count, last_index);
        end
    endtask

    task automatic test_fifo_equal();
        int lat; logic err; logic [KEY_W-1:0] rk;
        do_op(2'd0, 32'd4, lat, err, rk);
        total++;
        if (lat !== 4) begin bad++; $display("FAIL eq_first_lat: got %0d want 4", lat); end
        // A second equal key must stop above the first one: 2 shifts, not 3.
        do_op(2'd0, 32'd4, lat, err, rk);
        total++;
        if (lat !== 4) begin bad++; $display("FAIL eq_second_lat: got %0d want 4", lat); end
        total++;
        if (mem[1] !== 32'd4 || mem[2] !== 32'd4 || mem[3] !== 32'd5 || mem[4] !== 32'd9) begin
            bad++;
            $display("FAIL eq_order: mem1..4=%0d,%0d,%0d,%0d want 4,4,5,9", mem[1], mem[2], mem[3], mem[4]);
        end
        do_op(2'd1, '0, lat, err, rk);
        total++;
        if (lat !== 6 || err !== 1'b0 || rk !== 32'd3) begin
            bad++;
            $display("FAIL rem_c5: lat=%0d err=%b key=%0d want 6/0/3", lat, err, rk);
        end
        do_op(2'd1, '0, lat, err, rk);
        total++;
        if (lat !== 5 || rk !== 32'd4 || count !== CW'(3)) begin
            bad++;
            $display("FAIL rem_c4: lat=%0d key=%0d count=%0d want 5/4/3", lat, rk, count);
        end
        do_op(2'd1, '0, lat, err, rk);
        total++;
        if (lat !== 4 || rk !== 32'd4 || count !== CW'(2) || mem[0] !== 32'd5 || mem[1] !== 32'd9) begin
            bad++;
            $display("FAIL rem_c3: lat=%0d key=%0d count=%0d mem0..1=%0d,%0d want 4/4/2/5,9",
                     lat, rk, count, mem[0], mem[1]);
        end
    endtask

    task automatic test_clear();
        logic [KEY_W-1:0] keys [5] = '{32'd1, 32'd2, 32'd6, 32'd7, 32'd8};
        int               lats [5] = '{4, 4, 3, 3, 3};
        int lat; logic err; logic [KEY_W-1:0] rk; int rst0;
        for (int i = 0; i < 5; i++) begin
            do_op(2'd0, keys[i], lat, err, rk);
            total++;
            if (lat !== lats[i]) begin
                bad++;
                $display("FAIL fill_%0d_lat: got %0d want %0d", keys[i], lat, lats[i]);
            end
        end
        total++;
        if (count !== CW'(7)) begin bad++; $display("FAIL fill_count: got %0d want 7", count); end
        rst0 = cnt_rst_cnt;
        do_op(2'd2, '0, lat, err, rk);
        total++;
        if (lat !== 1 || err !== 1'b0 || cnt_rst_cnt - rst0 !== 1) begin
            bad++;
            $display("FAIL clear_rsp: lat=%0d err=%b cnt_rst pulses=%0d want 1/0/1",
                     lat, err, cnt_rst_cnt - rst0);
        end
        total++;
        if (count !== '0 || last_index !== 32'd0) begin
            bad++;
            $display("FAIL clear_count: count=%0d last_index=%0d want 0", count, last_index);
        end
    endtask

    task automatic test_errors();
        int lat; logic err; logic [KEY_W-1:0] rk; int we0;
        we0 = we_cnt;
        do_op(2'd1, '0, lat, err, rk);
        total++;
        if (lat !== 1 || err !== 1'b1 || rk !== '0 || we_cnt !== we0 || count !== '0) begin
            bad++;
            $display("FAIL rem_empty: lat=%0d err=%b key=%0d writes=%0d count=%0d want 1/1/0/0/0",
                     lat, err, rk, we_cnt - we0, count);
        end
        do_op(2'd3, 32'd77, lat, err, rk);
        total++;
        if (lat !== 1 || err !== 1'b1 || count !== '0) begin
            bad++;
            $display("FAIL illegal_op: lat=%0d err=%b count=%0d want 1/1/0", lat, err, count);
        end
        do_op(2'd0, 32'd50, lat, err, rk);
        total++;
        if (lat !== 2 || err !== 1'b0 || count !== CW'(1)) begin
            bad++;
            $display("FAIL err_cleared: lat=%0d err=%b count=%0d want 2/0/1", lat, err, count);
        end
    endtask

    task automatic test_full();
        int lat; logic err; logic [KEY_W-1:0] rk; int we0;
        do_op(2'd2, '0, lat, err, rk);
        for (int i = 0; i < DEPTH; i++) begin
            do_op(2'd0, 32'(100 + i), lat, err, rk);
            total++;
            if (lat !== 2 || err !== 1'b0) begin
                bad++;
                $display("FAIL full_fill_%0d: lat=%0d err=%b want 2/0", i, lat, err);
            end
        end
        total++;
        if (count !== CW'(DEPTH) || mem[0] !== 32'd100 || mem[DEPTH-1] !== 32'd115) begin
            bad++;
            $display("FAIL full_state: count=%0d mem0=%0d mem15=%0d want 16/100/115",
                     count, mem[0], mem[DEPTH-1]);
        end
        we0 = we_cnt;
        do_op(2'd0, 32'd7, lat, err, rk);
        total++;
        if (lat !== 1 || err !== 1'b1 || count !== CW'(DEPTH) || we_cnt !== we0) begin
            bad++;
            $display("FAIL ins_full: lat=%0d err=%b count=%0d writes=%0d want 1/1/16/0",
                     lat, err, count, we_cnt - we0);
        end
        do_op(2'd1, '0, lat, err, rk);
        total++;
        if (lat !== 17 || err !== 1'b0 || rk !== 32'd100 || count !== CW'(15)) begin
            bad++;
            $display("FAIL rem_full: lat=%0d err=%b key=%0d count=%0d want 17/0/100/15",
                     lat, err, rk, count);
        end
        total++;
        if (mem[0] !== 32'd101 || mem[14] !== 32'd115) begin
            bad++;
            $display("FAIL rem_full_shift: mem0=%0d mem14=%0d want 101/115", mem[0], mem[14]);
        end
    endtask

    task automatic test_reset_mid_op();
        int lat; logic err; logic [KEY_W-1:0] rk; int rsp0;
        do_op(2'd2, '0, lat, err, rk);
        do_op(2'd0, 32'd10, lat, err, rk);
        do_op(2'd0, 32'd20, lat, err, rk);
        do_op(2'd0, 32'd30, lat, err, rk);
        @(negedge clk);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = 2'd0;
        cmd_if.cmd_key   = 32'd5;
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
        total++;
        if (cmd_if.cmd_ready !== 1'b0) begin
            bad++;
            $display("FAIL walk_busy: cmd_ready=%b want 0", cmd_if.cmd_ready);
        end
        rsp0 = rsp_cnt;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (cmd_if.cmd_ready !== 1'b1 || count !== '0 || cmd_if.rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset: ready=%b count=%0d rsp_valid=%b want 1/0/0",
                     cmd_if.cmd_ready, count, cmd_if.rsp_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        total++;
        if (rsp_cnt !== rsp0) begin
            bad++;
            $display("FAIL mid_reset_rsp: %0d responses after abort want 0", rsp_cnt - rsp0);
        end
        do_op(2'd0, 32'd42, lat, err, rk);
        total++;
        if (lat !== 2 || err !== 1'b0 || count !== CW'(1) || mem[0] !== 32'd42) begin
            bad++;
            $display("FAIL post_reset_ins: lat=%0d err=%b count=%0d mem0=%0d want 2/0/1/42",
                     lat, err, count, mem[0]);
        end
    endtask

    initial begin
        test_reset();
        test_insert_sort();
        test_fifo_equal();
        test_clear();
        test_errors();
        test_full();
        test_reset_mid_op();
        total++;
        if (overlap_cnt !== 0) begin
            bad++;
            $display("FAIL strobe_onehot: %0d cycles with multiple strobes want 0", overlap_cnt);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
